id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_if.sv | 48 ++++
 rtl/id_ex_reg.sv | 120 ++++++++++++
 2 files changed

// File: rtl/id_ex_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_reg_if: the ID->EX pipeline bus.
//   master: ID-side producer (drives id_*, observes ex_*)
//   slave : the ID/EX pipeline register (consumes id_*, drives ex_*)
// ----------------------------------------------------------------------------
interface id_ex_reg_if;
    // ID-side decoded instruction
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic        id_re1;
    logic [4:0]  id_raddr1;
    logic        id_re2;
    logic [4:0]  id_raddr2;
    logic [15:0] id_ctrl;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        id_is_load;

    // EX-side registered instruction
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [15:0] ex_ctrl;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic        ex_is_load;

    modport master (
        output id_valid, id_pc, id_inst, id_rdata1, id_rdata2,
               id_re1, id_raddr1, id_re2, id_raddr2,
               id_ctrl, id_we, id_waddr, id_is_load,
        input  ex_valid, ex_pc, ex_inst, ex_src1, ex_src2,
               ex_ctrl, ex_we, ex_waddr, ex_is_load
    );

    modport slave (
        input  id_valid, id_pc, id_inst, id_rdata1, id_rdata2,
               id_re1, id_raddr1, id_re2, id_raddr2,
               id_ctrl, id_we, id_waddr, id_is_load,
        output ex_valid, ex_pc, ex_inst, ex_src1, ex_src2,
               ex_ctrl, ex_we, ex_waddr, ex_is_load
    );
endinterface : id_ex_reg_if

// File: rtl/id_ex_reg.sv
// ----------------------------------------------------------------------------
// id_ex_reg: ID/EX pipeline register with load-use interlock.
//   - One action per edge, in priority order: reset, flush, EX stall (hold),
//     load-use hazard (bubble), otherwise capture the ID instruction.
//   - stall_req tells IF/ID to hold while a load-use bubble is pending.
//   - Optional bubble counter, enabled by defining ID_EX_PERF_CNT_EN;
//     without it perf_bubble_cnt is tied to zero and no counter exists.
// ----------------------------------------------------------------------------
module id_ex_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_ex,
    id_ex_reg_if.slave  bus,
    output logic        stall_req,
    output logic [31:0] perf_bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_CLEAR,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } action_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [15:0] ctrl;
        logic        we;
        logic [4:0]  waddr;
        logic        is_load;
    } ex_t;

    ex_t     ex_q;
    ex_t     ex_from_id;
    action_t action;
    logic    src1_hit;
    logic    src2_hit;
    logic    hazard;

    // Load-use hazard: a valid ID instruction reads the nonzero destination
    // of the load currently in EX, whose data is not ready until MEM.
    always_comb begin
        src1_hit = bus.id_re1 && (bus.id_raddr1 == ex_q.waddr);
        src2_hit = bus.id_re2 && (bus.id_raddr2 == ex_q.waddr);
        hazard   = bus.id_valid && ex_q.valid && ex_q.is_load &&
                   (ex_q.waddr != 5'd0) && (src1_hit || src2_hit);
    end

    assign stall_req = hazard && !flush && !rst;

    // Select the single action for the coming edge, highest priority first.
    always_comb begin
        // NOTE: default assignment first so no path leaves action unassigned
        // (which would infer a latch).
        action = ACT_LOAD;
        if (rst)           action = ACT_CLEAR;
        else if (flush)    action = ACT_CLEAR;
        else if (stall_ex) action = ACT_HOLD;
        else if (hazard)   action = ACT_BUBBLE;
    end

    // Image of the ID instruction as it would appear in EX; writes and load
    // marking only survive for a valid instruction.
    always_comb begin
        ex_from_id.valid   = bus.id_valid;
        ex_from_id.pc      = bus.id_pc;
        ex_from_id.inst    = bus.id_inst;
        ex_from_id.src1    = bus.id_rdata1;
        ex_from_id.src2    = bus.id_rdata2;
        ex_from_id.ctrl    = bus.id_ctrl;
        ex_from_id.we      = bus.id_we && bus.id_valid;
        ex_from_id.waddr   = bus.id_waddr;
        ex_from_id.is_load = bus.id_is_load && bus.id_valid;
    end

    // EX register: clear, hold, bubble or capture per the selected action.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        case (action)
            ACT_CLEAR:  ex_q <= '0;
            ACT_BUBBLE: ex_q <= '0;
            ACT_HOLD:   ex_q <= ex_q;
            ACT_LOAD:   ex_q <= ex_from_id;
            default:    ex_q <= '0;
        endcase
    end

    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_pc      = ex_q.pc;
    assign bus.ex_inst    = ex_q.inst;
    assign bus.ex_src1    = ex_q.src1;
    assign bus.ex_src2    = ex_q.src2;
    assign bus.ex_ctrl    = ex_q.ctrl;
    assign bus.ex_we      = ex_q.we;
    assign bus.ex_waddr   = ex_q.waddr;
    assign bus.ex_is_load = ex_q.is_load;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;

    // Saturating count of inserted bubbles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            bubble_cnt_q <= '0;
        else if (action == ACT_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end

    assign perf_bubble_cnt = bubble_cnt_q;
`else
    assign perf_bubble_cnt = 32'd0;
`endif

endmodule : id_ex_reg
